// File: rtl/dmem_lsu_ctrl_if.sv
// CPU request/response and data-memory request/response bundle for dmem_lsu_ctrl.
// slave = the controller's view, master = the CPU/memory environment's view.
interface dmem_lsu_ctrl_if #(
  parameter int WORDSIZE = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [WORDSIZE-1:0] req_addr;
  logic [WORDSIZE-1:0] req_wdata;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORDSIZE-1:0] rsp_rdata;
  logic                rsp_err;
  logic [WORDSIZE-1:0] dmem_addr;
  logic [3:0]          dmem_rmask;
  logic [3:0]          dmem_wmask;
  logic [WORDSIZE-1:0] dmem_wdata;
  logic [WORDSIZE-1:0] dmem_rdata;
  logic                dmem_resp;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dmem_rdata, dmem_resp,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, dmem_rdata, dmem_resp,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Load/store front-end for data_memory: one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW op in flight.
// Optional WAIT-state timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_lsu_ctrl #(
  parameter int WORDSIZE       = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_lsu_ctrl_if.slave  bus
);

  if (WORDSIZE != 32) begin : g_ws_chk
    $error("dmem_lsu_ctrl supports WORDSIZE=32 only");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_to_chk
    $error("dmem_lsu_ctrl needs TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_BAD = 2'd3;

  function automatic logic [1:0] size_of(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      3'b000, 3'b100: sz = SZ_B;
      3'b001, 3'b101: sz = SZ_H;
      3'b010:         sz = SZ_W;
      default:        sz = SZ_BAD;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_rep(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {4{wd[7:0]}};
      SZ_H:    r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // funct3[2] selects zero-extension; byte/half lanes are first shifted down to bit 0.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {off, 3'b000};
    case (size_of(f3))
      SZ_B:    r = {{24{~f3[2] & sh[7]}}, sh[7:0]};
      SZ_H:    r = {{16{~f3[2] & sh[15]}}, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_rmask_q, dmem_rmask_d;
  logic [3:0]  dmem_wmask_q, dmem_wmask_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  req_sz_s;
  logic        req_bad_s;

`ifdef DMEM_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Request decode: size class plus illegal/misaligned classification.
  always_comb begin
    req_sz_s  = size_of(bus.req_funct3);
    req_bad_s = (req_sz_s == SZ_BAD)
              | (bus.req_we & bus.req_funct3[2])
              | ((req_sz_s == SZ_H) & bus.req_addr[0])
              | ((req_sz_s == SZ_W) & (bus.req_addr[1:0] != 2'b00));
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_rmask_d = 4'b0000;
    dmem_wmask_d = 4'b0000;
    dmem_wdata_d = dmem_wdata_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = bus.req_we;
          f3_d        = bus.req_funct3;
          off_d       = bus.req_addr[1:0];
          if (req_bad_s) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            // Memory-side outputs are registered here so they are live for the whole ACCESS cycle.
            state_d      = ACCESS;
            dmem_addr_d  = {bus.req_addr[31:2], 2'b00};
            dmem_wdata_d = store_rep(req_sz_s, bus.req_wdata);
            if (bus.req_we) begin
              dmem_wmask_d = lane_mask(req_sz_s, bus.req_addr[1:0]);
            end else begin
              dmem_rmask_d = lane_mask(req_sz_s, bus.req_addr[1:0]);
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = WAIT;
`ifdef DMEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (bus.dmem_resp) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? 32'h0000_0000 : load_fmt(f3_q, off_q, bus.dmem_rdata);
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State and output registers; async reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0000_0000;
      dmem_addr_q  <= 32'h0000_0000;
      dmem_rmask_q <= 4'b0000;
      dmem_wmask_q <= 4'b0000;
      dmem_wdata_q <= 32'h0000_0000;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_rmask_q <= dmem_rmask_d;
      dmem_wmask_q <= dmem_wmask_d;
      dmem_wdata_q <= dmem_wdata_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_rmask = dmem_rmask_q;
  assign bus.dmem_wmask = dmem_wmask_q;
  assign bus.dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Self-checking bench for dmem_lsu_ctrl: directed vector table, random ops against a byte-lane
// reference model, and hand-written hold / reset / timeout sequences.
module tb_dmem_lsu_ctrl;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  dmem_lsu_ctrl_if #(.WORDSIZE(32)) bus ();

  dmem_lsu_ctrl #(.WORDSIZE(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic        err;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] dw;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-lane reference: which lanes an op touches and what the CPU should see back.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] mem,
                                output logic err, output logic [3:0] rm, output logic [3:0] wm,
                                output logic [31:0] dw, output logic [31:0] rd);
    int     nb;
    bit     sgn;
    int     off;
    longint v;
    off = int'(a[1:0]);
    rm = 4'h0; wm = 4'h0; dw = 32'h0; rd = 32'h0;
    case (f3)
      3'd0:    begin nb = 1; sgn = 1'b1; end
      3'd1:    begin nb = 2; sgn = 1'b1; end
      3'd2:    begin nb = 4; sgn = 1'b1; end
      3'd4:    begin nb = 1; sgn = 1'b0; end
      3'd5:    begin nb = 2; sgn = 1'b0; end
      default: begin nb = 0; sgn = 1'b0; end
    endcase
    err = (nb == 0) || (we && f3 >= 3'd4) || (nb != 0 && (off % nb) != 0);
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + nb) begin
          if (we) wm[i] = 1'b1;
          else    rm[i] = 1'b1;
        end
        dw[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
      if (!we) begin
        v = 0;
        for (int k = 0; k < nb; k++) v += longint'(mem[8*(off+k) +: 8]) << (8*k);
        if (sgn && v >= (longint'(1) << (8*nb - 1))) v -= (longint'(1) << (8*nb));
        rd = 32'(v);
      end
    end
  endfunction

  task automatic scramble();
    bus.req_valid  = 1'($urandom_range(0, 1));
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.dmem_rdata = $urandom;
    bus.dmem_resp  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  // One complete op: issue, observe ACCESS/WAIT, answer after lat idle WAIT cycles,
  // hold the response for hold cycles, then complete the response handshake.
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mem,
                       input logic e_err, input logic [3:0] e_rm, input logic [3:0] e_wm,
                       input logic [31:0] e_dw, input logic [31:0] e_rd,
                       input int lat, input int hold);
    int          n;
    int          stable;
    logic [3:0]  stray;
    logic [31:0] held_rd;
    logic        held_err;
    wait_ready(tag);
    if (bus.req_ready !== 1'b1) return;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    scramble();
    if (e_err) begin
      chk({tag, ".err_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".err_masks"}, 32'({bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    end else begin
      chk({tag, ".access_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, ".rmask"}, 32'(bus.dmem_rmask), 32'(e_rm));
      chk({tag, ".wmask"}, 32'(bus.dmem_wmask), 32'(e_wm));
      chk({tag, ".dmem_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
      if (we) chk({tag, ".dmem_wdata"}, bus.dmem_wdata, e_dw);
      bus.dmem_resp = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      scramble();
      stray = 4'h0;
      for (int i = 0; i < lat; i++) begin
        stray |= bus.dmem_rmask | bus.dmem_wmask | {3'b000, bus.rsp_valid};
        @(posedge clk); #1;
        scramble();
      end
      stray |= bus.dmem_rmask | bus.dmem_wmask | {3'b000, bus.rsp_valid};
      bus.dmem_resp  = 1'b1;
      bus.dmem_rdata = mem;
      @(posedge clk); #1;
      scramble();
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 4) begin
        @(posedge clk); #1;
        scramble();
        n++;
      end
      chk({tag, ".wait_quiet"}, 32'(stray), 32'd0);
      chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    end
    chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(e_err));
    chk({tag, ".rsp_rdata"}, bus.rsp_rdata, e_rd);
    held_rd  = bus.rsp_rdata;
    held_err = bus.rsp_err;
    if (hold > 0) begin
      stable = 0;
      for (int i = 0; i < hold; i++) begin
        bus.req_valid = 1'b1;
        bus.dmem_resp = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (bus.rsp_valid === 1'b1 && bus.rsp_rdata === held_rd && bus.rsp_err === held_err &&
            bus.req_ready === 1'b0 && bus.dmem_rmask === 4'h0 && bus.dmem_wmask === 4'h0)
          stable++;
      end
      chk({tag, ".hold_stable_cycles"}, 32'(stable), 32'(hold));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.dmem_resp = 1'b0;
    chk({tag, ".post_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".post_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic        r_err;
    logic [3:0]  r_rm, r_wm;
    logic [31:0] r_dw, r_rd, r_a, r_wd, r_mem;
    logic        r_we;
    logic [2:0]  r_f3;
    int          n;

    //            we    f3      addr          wdata         mem           err   rm    wm    dw            rd
    vt[0]  = '{1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'h0, 4'hF, 32'hDEAD_BEEF, 32'h0};
    vt[1]  = '{1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0,        1'b0, 4'h0, 4'h8, 32'hA5A5_A5A5, 32'h0};
    vt[2]  = '{1'b0, 3'b000, 32'h0000_0013, 32'h0,         32'hA500_0000, 1'b0, 4'h8, 4'h0, 32'h0,        32'hFFFF_FFA5};
    vt[3]  = '{1'b0, 3'b100, 32'h0000_0013, 32'h0,         32'hA500_0000, 1'b0, 4'h8, 4'h0, 32'h0,        32'h0000_00A5};
    vt[4]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0,         32'h8001_0000, 1'b0, 4'hC, 4'h0, 32'h0,        32'hFFFF_8001};
    vt[5]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h8001_0000, 1'b0, 4'hC, 4'h0, 32'h0,        32'h0000_8001};
    vt[6]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         32'h1111_1111, 1'b1, 4'h0, 4'h0, 32'h0,        32'h0};
    vt[7]  = '{1'b1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0,        1'b1, 4'h0, 4'h0, 32'h0,        32'h0};
    vt[8]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,         32'h2222_2222, 1'b1, 4'h0, 4'h0, 32'h0,        32'h0};
    vt[9]  = '{1'b1, 3'b100, 32'h0000_0004, 32'h0000_0077, 32'h0,        1'b1, 4'h0, 4'h0, 32'h0,        32'h0};
    vt[10] = '{1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0, 4'hF, 4'h0, 32'h0,        32'h1234_5678};
    vt[11] = '{1'b0, 3'b000, 32'h0000_0021, 32'h0,         32'h0000_8000, 1'b0, 4'h2, 4'h0, 32'h0,        32'hFFFF_FF80};
    vt[12] = '{1'b1, 3'b001, 32'h0000_0002, 32'h1234_BEEF, 32'h0,        1'b0, 4'h0, 4'hC, 32'hBEEF_BEEF, 32'h0};
    vt[13] = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,         32'h0000_FFFF, 1'b0, 4'h3, 4'h0, 32'h0,        32'h0000_FFFF};
    vt[14] = '{1'b1, 3'b111, 32'h0000_0008, 32'h0,         32'h0,        1'b1, 4'h0, 4'h0, 32'h0,        32'h0};
    vt[15] = '{1'b0, 3'b110, 32'h0000_0008, 32'h0,         32'h3333_3333, 1'b1, 4'h0, 4'h0, 32'h0,        32'h0};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    bus.dmem_rdata = 32'h0; bus.dmem_resp = 1'b0;

    #2;
    chk("reset.outputs_zero",
        32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    chk("reset.rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset.dmem_addr", bus.dmem_addr, 32'h0);
    chk("reset.dmem_wdata", bus.dmem_wdata, 32'h0);
    @(posedge clk); #1;
    chk("reset.req_ready_held", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.req_ready_first_edge", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].mem,
            vt[i].err, vt[i].rm, vt[i].wm, vt[i].dw, vt[i].rd, $urandom_range(0, 2), 0);
    end

    // Response back-pressure with a competing request pending.
    do_op("hold", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D,
          1'b0, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D, 1, 5);
    do_op("hold_err", 1'b0, 3'b001, 32'h0000_0043, 32'h0, 32'h0,
          1'b1, 4'h0, 4'h0, 32'h0, 32'h0, 0, 3);

    // Reset while WAITing: op dropped, outputs clear asynchronously, stale resp ignored.
    wait_ready("rst_wait");
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_0060; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_wait.access_rmask", 32'(bus.dmem_rmask), 32'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_wait.outputs_zero",
        32'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.dmem_rmask, bus.dmem_wmask}), 32'd0);
    chk("rst_wait.dmem_addr", bus.dmem_addr, 32'h0);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dmem_resp = 1'b0;
    chk("rst_wait.req_ready_after", 32'(bus.req_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.rsp_valid !== 1'b0) n++;
      @(posedge clk); #1;
    end
    chk("rst_wait.no_response", 32'(n), 32'd0);

`ifdef DMEM_TIMEOUT_EN
    // Memory never answers: timeout error after TO WAIT cycles; a late resp is ignored.
    wait_ready("timeout");
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0000_0050; bus.req_wdata = 32'h0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("timeout.access_rmask", 32'(bus.dmem_rmask), 32'hF);
    @(posedge clk); #1;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 12) begin
      n++;
      @(posedge clk); #1;
    end
    chk("timeout.wait_cycles", 32'(n), 32'(TO));
    chk("timeout.rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("timeout.rsp_rdata", bus.rsp_rdata, 32'h0);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.dmem_resp = 1'b0;
    chk("timeout.late_resp_ignored",
        32'({bus.rsp_valid, bus.rsp_err, bus.dmem_rmask, bus.dmem_wmask}), 32'h300);
    chk("timeout.late_rdata", bus.rsp_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("timeout.post_req_ready", 32'(bus.req_ready), 32'd1);
`else
    // Without the timeout a slow memory simply stretches WAIT.
    do_op("slow_mem", 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h5A5A_5A5A,
          1'b0, 4'hF, 4'h0, 32'h0, 32'h5A5A_5A5A, 12, 0);
`endif

    for (int i = 0; i < 120; i++) begin
      r_we  = 1'($urandom);
      r_f3  = 3'($urandom);
      r_a   = $urandom_range(0, 255);
      r_wd  = $urandom;
      r_mem = $urandom;
      model(r_we, r_f3, r_a, r_wd, r_mem, r_err, r_rm, r_wm, r_dw, r_rd);
      do_op($sformatf("rnd%0d", i), r_we, r_f3, r_a, r_wd, r_mem,
            r_err, r_rm, r_wm, r_dw, r_rd, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store front-end that sits directly upstream of data_memory and drives its dmem_* request port.
- Accepts one CPU memory op at a time over a valid/ready handshake, covering RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW.
- Generates word-aligned address, byte masks and replicated store data; waits for dmem_resp.
- Returns aligned, sign/zero-extended load data, or an error for misaligned/illegal ops, over a second valid/ready handshake.

Parameters:
WORDSIZE, 32, data/address width; only 32 is supported (masks are 4 bits)
TIMEOUT_CYCLES, 16, WAIT-state cycles before timeout error; used only when DMEM_TIMEOUT_EN is defined

Ports:
clk  input  1  clock; all flops on posedge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request valid
req_ready  output  1  ctrl can accept request (registered)
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V funct3 size/sign
req_addr  input  WORDSIZE  byte address
req_wdata  input  WORDSIZE  store data, LSB-justified
rsp_valid  output  1  response valid
rsp_ready  input  1  CPU accepts response
rsp_rdata  output  WORDSIZE  load result, extended; 0 for stores/errors
rsp_err  output  1  misaligned, illegal funct3 or timeout
dmem_addr  output  WORDSIZE  word-aligned address {addr[31:2],2'b00}
dmem_rmask  output  4  byte read mask
dmem_wmask  output  4  byte write mask
dmem_wdata  output  WORDSIZE  replicated store data
dmem_rdata  input  WORDSIZE  memory read data, valid while dmem_resp=1
dmem_resp  input  1  memory response

Behaviour:
- Reset (rst_n=0, async): state=IDLE; req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, dmem_addr=0, dmem_rmask=0, dmem_wmask=0, dmem_wdata=0.
- req_ready goes to 1 on the first clk edge with rst_n=1.
- States:
  - IDLE: req_ready=1. On req_valid, latch we/funct3/addr/wdata, drop req_ready, then:
    - misaligned or illegal funct3 -> RESP with rsp_err=1;
    - otherwise -> ACCESS.
  - ACCESS: exactly one cycle. Drive dmem_addr, dmem_wdata and a nonzero rmask (load) or wmask (store); the other mask is 0. Next state WAIT.
  - WAIT: both masks 0. On dmem_resp=1: capture formatted dmem_rdata (loads) or 0 (stores), -> RESP.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready, then -> IDLE (req_ready=1 the following cycle).
- Nominal timing (resp arriving 1 cycle after ACCESS): accept at edge T -> ACCESS T+1 -> dmem_resp seen T+2 -> rsp_valid from T+3.
- Throughput: one op in flight at a time.
- Size decode from funct3:
  - 000/100 = byte; 001/101 = half; 010 = word. 000/001/010 are signed loads; 100/101 are unsigned.
  - Illegal: 011, 110, 111, and any store with funct3[2]=1.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Masks:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word unchanged.
- Load data: shift dmem_rdata right by 8*addr[1:0], then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) from 8/16 bits.
- Simultaneous events and boundaries:
  - req_valid is ignored outside IDLE.
  - A dmem_resp outside WAIT is ignored.
  - rsp_ready without rsp_valid has no effect.
  - A response held for many cycles causes no memory traffic.
- Reset mid-operation: the op is dropped, no response is produced, masks go to 0 immediately (async).

Optional Feature:
DMEM_TIMEOUT_EN
- Defined: a cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle without dmem_resp.
  - On reaching TIMEOUT_CYCLES: -> RESP with rsp_err=1, rsp_rdata=0.
  - dmem_resp in the same cycle as the timeout wins (normal response).
  - A late dmem_resp after timeout is ignored.
- Not defined: WAIT holds indefinitely, no counter logic exists, TIMEOUT_CYCLES is unused.

Test Plan:
1. After reset, SW addr=0x0000_0010 wdata=0xDEAD_BEEF -> ACCESS cycle shows dmem_addr=0x10, wmask=4'b1111, rmask=0, wdata=0xDEADBEEF; then rsp_valid=1, rsp_err=0, rsp_rdata=0.
2. SB addr=0x13 wdata=0x0000_00A5 -> wmask=4'b1000, dmem_wdata=0xA5A5A5A5. LB addr=0x13 with memory word 0xA5000000 -> rsp_rdata=0xFFFF_FFA5. LBU -> 0x0000_00A5.
3. LH addr=0x12, memory word 0x8001_0000 -> rmask=4'b1100, rsp_rdata=0xFFFF_8001. LHU -> 0x0000_8001.
4. LW addr=0x06; separately SH addr=0x01 and funct3=3'b011 -> no nonzero mask ever driven; rsp_err=1, rsp_rdata=0 the cycle after accept.
5. Hold rsp_ready=0 for 5 cycles with req_valid=1 -> rsp_valid/rsp_rdata stable, req_ready=0, masks 0; assert rsp_ready -> req_ready=1 next cycle. Pulse rst_n low during WAIT -> no response, outputs 0.
6. DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, dmem_resp tied 0 on a LW -> rsp_err=1 after 4 WAIT cycles; a dmem_resp injected afterwards -> ignored.
